// File: rtl/expr_pipe.sv
// Four-stage streaming evaluator of q = ((a - b)*(1 + 3c) - 4d) / 2 with valid/ready flow control.
// Define EXPR_PIPE_SAT_EN to saturate q on overflow; otherwise q wraps to WIDTH bits.
module expr_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int DW = WIDTH + 1;
  localparam int TW = WIDTH + 3;
  localparam int FW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 4;
  localparam int SW = 2 * WIDTH + 5;

  localparam logic signed [TW-1:0] ONE_T = TW'(1);

  // Halve with truncation toward zero: bias negative odd values up by one first.
  function automatic logic signed [SW-1:0] div2_tz(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] adj;
    adj = s + $signed({{(SW-1){1'b0}}, s[SW-1] & s[0]});
    return adj >>> 1;
  endfunction

  // Returns {ovf, q}: overflow when r's bits above WIDTH-1 are not a pure sign extension.
  function automatic logic [WIDTH:0] reduce(input logic signed [SW-1:0] r);
    logic [SW-WIDTH:0] top;
    logic              of;
    logic [WIDTH-1:0]  qv;
    top = r[SW-1:WIDTH-1];
    of  = !((top == '0) || (top == '1));
    qv  = r[WIDTH-1:0];
`ifdef EXPR_PIPE_SAT_EN
    if (of) qv = r[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {of, qv};
  endfunction

  logic en;

  logic signed [DW-1:0] diff_d;
  logic signed [TW-1:0] c_ext;
  logic signed [TW-1:0] t_d;
  logic signed [FW-1:0] d4_d;

  logic                 vld_p1_q;
  logic [TAG_W-1:0]     tag_p1_q;
  logic signed [DW-1:0] diff_p1_q;
  logic signed [TW-1:0] t_p1_q;
  logic signed [FW-1:0] d4_p1_q;

  logic signed [PW-1:0] prod_d;
  logic                 vld_p2_q;
  logic [TAG_W-1:0]     tag_p2_q;
  logic signed [PW-1:0] prod_p2_q;
  logic signed [FW-1:0] d4_p2_q;

  logic signed [SW-1:0] sub_d;
  logic                 vld_p3_q;
  logic [TAG_W-1:0]     tag_p3_q;
  logic signed [SW-1:0] sub_p3_q;

  logic signed [SW-1:0] r_d;
  logic [WIDTH-1:0]     q_d;
  logic                 ovf_d;
  logic                 vld_p4_q;
  logic [TAG_W-1:0]     tag_p4_q;
  logic [WIDTH-1:0]     q_p4_q;
  logic                 ovf_p4_q;
  logic [CNT_W-1:0]     cnt_q;

  // Whole pipe moves together; it only stalls when a presented result is not taken.
  assign en       = !vld_p4_q || out_ready;
  assign in_ready = en;

  // S1: operand pre-scaling at full precision
  always_comb begin
    diff_d = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    c_ext  = $signed({{3{c[WIDTH-1]}}, c});
    t_d    = (c_ext <<< 1) + c_ext + ONE_T;
    d4_d   = $signed({d[WIDTH-1], d, 2'b00});
  end

  // S2: product
  always_comb begin
    prod_d = PW'(diff_p1_q) * PW'(t_p1_q);
  end

  // S3: subtract scaled d
  always_comb begin
    sub_d = SW'(prod_p2_q) - SW'(d4_p2_q);
  end

  // S4: halve, range check and reduce to WIDTH bits
  always_comb begin
    r_d            = div2_tz(sub_p3_q);
    {ovf_d, q_d}   = reduce(r_d);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag_p1_q  <= in_tag;
      diff_p1_q <= diff_d;
      t_p1_q    <= t_d;
      d4_p1_q   <= d4_d;
      tag_p2_q  <= tag_p1_q;
      prod_p2_q <= prod_d;
      d4_p2_q   <= d4_p1_q;
      tag_p3_q  <= tag_p2_q;
      sub_p3_q  <= sub_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      tag_p4_q <= '0;
      q_p4_q   <= '0;
      ovf_p4_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (en) begin
        vld_p1_q <= in_valid;
        vld_p2_q <= vld_p1_q;
        vld_p3_q <= vld_p2_q;
        vld_p4_q <= vld_p3_q;
        if (vld_p3_q) begin
          tag_p4_q <= tag_p3_q;
          q_p4_q   <= q_d;
          ovf_p4_q <= ovf_d;
        end
      end
      if (vld_p4_q && out_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = vld_p4_q;
  assign q         = q_p4_q;
  assign out_tag   = tag_p4_q;
  assign ovf       = ovf_p4_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_expr_pipe.sv
// Directed and randomised checks of expr_pipe at WIDTH=32 and WIDTH=8.
module tb_expr_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, ovf32;
  logic [31:0] a32, b32, c32, d32, q32;
  logic [3:0]  it32, ot32;
  logic [15:0] cnt32;

  logic        iv8, ir8, ov8, or8, ovf8;
  logic [7:0]  a8, b8, c8, d8, q8;
  logic [3:0]  it8, ot8;
  logic [15:0] cnt8;

  expr_pipe #(.WIDTH(32), .TAG_W(4), .CNT_W(16)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .c(c32), .d(d32), .in_tag(it32),
    .out_valid(ov32), .out_ready(or32), .q(q32), .out_tag(ot32),
    .ovf(ovf32), .out_cnt(cnt32));

  expr_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .c(c8), .d(d8), .in_tag(it8),
    .out_valid(ov8), .out_ready(or8), .q(q8), .out_tag(ot8),
    .ovf(ovf8), .out_cnt(cnt8));

  int chk_cnt = 0;
  int pass_cnt = 0;

  int          lat;
  logic [31:0] rq;
  logic        rovf;
  logic [3:0]  rtag;
  logic [7:0]  rq8;

  typedef struct packed {
    logic [7:0] q;
    logic       ovf;
    logic [3:0] tag;
  } exp_t;

`ifdef EXPR_PIPE_SAT_EN
  localparam logic [31:0] EQ5 = 32'h7FFF_FFFF;
  localparam logic [31:0] EQ6 = 32'h7FFF_FFFF;
  localparam logic [7:0]  EO_POS = 8'd127;
  localparam logic [7:0]  EO_NEG = 8'h80;
`else
  localparam logic [31:0] EQ5 = 32'hFFFF_FFFE;
  localparam logic [31:0] EQ6 = 32'h0000_0000;
  localparam logic [7:0]  EO_POS = 8'd65;
  localparam logic [7:0]  EO_NEG = 8'hBF;
`endif

  localparam logic [31:0] RA [0:6] = '{32'd0, 32'hFFFF_FFFD, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0};
  localparam logic [31:0] RB [0:6] = '{32'd1, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd0};
  localparam logic [31:0] RC [0:6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 32'd0};
  localparam logic [31:0] RD [0:6] = '{32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'h8000_0000};
  localparam logic [31:0] RQ [0:6] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0001, 32'h7FFF_FFFF, EQ5, EQ6};
  localparam logic        RO [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic exp_t model8(input logic [7:0] ia, ib, ic, id, input logic [3:0] tg);
    exp_t   e;
    longint sa, sb, sc, sd, s, r;
    sa = $signed(ia); sb = $signed(ib); sc = $signed(ic); sd = $signed(id);
    s = (sa - sb) * (1 + 3 * sc) - 4 * sd;
    r = s / 2;
    e.ovf = (r > 127) || (r < -128);
    e.q   = r[7:0];
`ifdef EXPR_PIPE_SAT_EN
    if (e.ovf) e.q = (r < 0) ? 8'h80 : 8'h7F;
`endif
    e.tag = tg;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    iv32 = 0; or32 = 0; a32 = 0; b32 = 0; c32 = 0; d32 = 0; it32 = 0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; c8 = 0; d8 = 0; it8 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic xact32(input logic [31:0] ia, ib, ic, id, input logic [3:0] itg,
                        output logic [31:0] oq, output logic oovf, output logic [3:0] otg,
                        output int olat);
    @(negedge clk);
    a32 = ia; b32 = ib; c32 = ic; d32 = id; it32 = itg; iv32 = 1; or32 = 1;
    olat = 0;
    do begin
      @(posedge clk); olat++; #1; iv32 = 0;
    end while (!ov32 && olat < 20);
    oq = q32; oovf = ovf32; otg = ot32;
  endtask

  task automatic xact8(input logic [7:0] ia, ib, ic, id, input logic [3:0] itg,
                       output logic [7:0] oq, output logic oovf, output logic [3:0] otg,
                       output int olat);
    @(negedge clk);
    a8 = ia; b8 = ib; c8 = ic; d8 = id; it8 = itg; iv8 = 1; or8 = 1;
    olat = 0;
    do begin
      @(posedge clk); olat++; #1; iv8 = 0;
    end while (!ov8 && olat < 20);
    oq = q8; oovf = ovf8; otg = ot8;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    chk_cnt++; if (ov32 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov32); else pass_cnt++;
    chk_cnt++; if (ir32 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir32); else pass_cnt++;
    chk_cnt++; if (q32 !== 32'd0) $display("FAIL reset_q: got %h want 0", q32); else pass_cnt++;
    chk_cnt++; if (ot32 !== 4'd0) $display("FAIL reset_tag: got %h want 0", ot32); else pass_cnt++;
    chk_cnt++; if (ovf32 !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf32); else pass_cnt++;
    chk_cnt++; if (cnt32 !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", cnt32); else pass_cnt++;
    chk_cnt++; if (ov8 !== 1'b0) $display("FAIL reset_out_valid8: got %b want 0", ov8); else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    xact32(32'd5, 32'd3, 32'd2, 32'd1, 4'd3, rq, rovf, rtag, lat);
    chk_cnt++; if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat); else pass_cnt++;
    chk_cnt++; if (rq !== 32'd5) $display("FAIL basic_q: got %0d want 5", $signed(rq)); else pass_cnt++;
    chk_cnt++; if (rtag !== 4'd3) $display("FAIL basic_tag: got %0d want 3", rtag); else pass_cnt++;
    chk_cnt++; if (rovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", rovf); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (cnt32 !== 16'd1) $display("FAIL basic_cnt: got %0d want 1", cnt32); else pass_cnt++;
  endtask

  task automatic test_rounding();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      xact32(RA[i], RB[i], RC[i], RD[i], 4'(i), rq, rovf, rtag, lat);
      chk_cnt++; if (rq !== RQ[i]) $display("FAIL round_q[%0d]: got %h want %h", i, rq, RQ[i]); else pass_cnt++;
      chk_cnt++; if (rovf !== RO[i]) $display("FAIL round_ovf[%0d]: got %b want %b", i, rovf, RO[i]); else pass_cnt++;
      chk_cnt++; if (rtag !== 4'(i)) $display("FAIL round_tag[%0d]: got %0d want %0d", i, rtag, i); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    xact8(8'd127, 8'h80, 8'd127, 8'd0, 4'd5, rq8, rovf, rtag, lat);
    chk_cnt++; if (rq8 !== EO_POS) $display("FAIL ovf_pos_q: got %0d want %0d", $signed(rq8), $signed(EO_POS)); else pass_cnt++;
    chk_cnt++; if (rovf !== 1'b1) $display("FAIL ovf_pos_flag: got %b want 1", rovf); else pass_cnt++;
    chk_cnt++; if (rtag !== 4'd5) $display("FAIL ovf_pos_tag: got %0d want 5", rtag); else pass_cnt++;
    xact8(8'h80, 8'd127, 8'd127, 8'd0, 4'd6, rq8, rovf, rtag, lat);
    chk_cnt++; if (rq8 !== EO_NEG) $display("FAIL ovf_neg_q: got %0d want %0d", $signed(rq8), $signed(EO_NEG)); else pass_cnt++;
    chk_cnt++; if (rovf !== 1'b1) $display("FAIL ovf_neg_flag: got %b want 1", rovf); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int acc = 0, nt = 0, et = 0, gaps = 0;
    do_reset();
    or32 = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      iv32 = 1; it32 = nt[3:0]; a32 = 32'(2 * nt); b32 = 0; c32 = 0; d32 = 0;
      #1;
      if (iv32 && ir32) begin acc++; nt++; end
    end
    chk_cnt++; if (acc !== 4) $display("FAIL bp_accepts: got %0d want 4", acc); else pass_cnt++;
    chk_cnt++; if (ir32 !== 1'b0) $display("FAIL bp_in_ready_low: got %b want 0", ir32); else pass_cnt++;
    chk_cnt++; if (ot32 !== 4'd0) $display("FAIL bp_held_tag: got %0d want 0", ot32); else pass_cnt++;
    @(negedge clk);
    or32 = 1; it32 = nt[3:0]; a32 = 32'(2 * nt);
    #1;
    chk_cnt++; if (ir32 !== 1'b1) $display("FAIL bp_in_ready_rise: got %b want 1", ir32); else pass_cnt++;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        it32 = nt[3:0]; a32 = 32'(2 * nt);
        #1;
      end
      if (!ov32) gaps++;
      if (ov32 && or32) begin
        chk_cnt++; if (ot32 !== et[3:0]) $display("FAIL bp_tag: got %0d want %0d", ot32, et[3:0]); else pass_cnt++;
        chk_cnt++; if (q32 !== 32'(et)) $display("FAIL bp_q: got %0d want %0d", q32, et); else pass_cnt++;
        et++;
      end
      if (iv32 && ir32) nt++;
    end
    chk_cnt++; if (gaps !== 0) $display("FAIL bp_gaps: got %0d want 0", gaps); else pass_cnt++;
    @(negedge clk);
    iv32 = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (ov32 && or32) begin
        chk_cnt++; if (ot32 !== et[3:0]) $display("FAIL bp_drain_tag: got %0d want %0d", ot32, et[3:0]); else pass_cnt++;
        et++;
      end
      @(negedge clk);
    end
    chk_cnt++; if (et !== nt) $display("FAIL bp_delivered: got %0d want %0d", et, nt); else pass_cnt++;
    chk_cnt++; if (cnt32 !== 16'(nt)) $display("FAIL bp_cnt: got %0d want %0d", cnt32, nt); else pass_cnt++;
  endtask

  task automatic test_random();
    exp_t sb[$];
    exp_t e;
    int sent = 0, xfers = 0, cyc = 0;
    do_reset();
    while ((sent < 1000 || sb.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      iv8 = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      it8 = sent[3:0];
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov8 && or8) begin
        if (sb.size() == 0) begin
          chk_cnt++; $display("FAIL rand_spurious: got out_valid with tag %0d want no result", ot8);
        end else begin
          e = sb.pop_front();
          chk_cnt++;
          if ({q8, ovf8, ot8} !== {e.q, e.ovf, e.tag})
            $display("FAIL rand_result: got q=%h ovf=%b tag=%0d want q=%h ovf=%b tag=%0d", q8, ovf8, ot8, e.q, e.ovf, e.tag);
          else pass_cnt++;
        end
        xfers++;
      end
      if (iv8 && ir8) begin
        sb.push_back(model8(a8, b8, c8, d8, it8));
        sent++;
      end
    end
    iv8 = 0;
    chk_cnt++; if (sent !== 1000 || sb.size() !== 0) $display("FAIL rand_timeout: got sent=%0d pending=%0d want 1000/0", sent, sb.size()); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (cnt8 !== 16'(xfers)) $display("FAIL rand_cnt: got %0d want %0d", cnt8, xfers); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    xact32(32'd7, 32'd1, 32'd0, 32'd0, 4'd1, rq, rovf, rtag, lat);
    @(posedge clk); #1;
    chk_cnt++; if (cnt32 !== 16'd1) $display("FAIL mid_cnt_before: got %0d want 1", cnt32); else pass_cnt++;
    @(negedge clk);
    or32 = 0;
    for (int i = 0; i < 3; i++) begin
      iv32 = 1; it32 = 4'(4 + i); a32 = 32'(20 + 2 * i); b32 = 0; c32 = 0; d32 = 0;
      @(negedge clk);
    end
    iv32 = 0;
    @(posedge clk); #2;
    chk_cnt++; if (ov32 !== 1'b1 || q32 !== 32'd10) $display("FAIL mid_preload: got v=%b q=%0d want v=1 q=10", ov32, q32); else pass_cnt++;
    #1; rst = 1'b1; #1;
    chk_cnt++; if (ov32 !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", ov32); else pass_cnt++;
    chk_cnt++; if (q32 !== 32'd0) $display("FAIL mid_q: got %0d want 0", q32); else pass_cnt++;
    chk_cnt++; if (cnt32 !== 16'd0) $display("FAIL mid_cnt: got %0d want 0", cnt32); else pass_cnt++;
    chk_cnt++; if (ir32 !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", ir32); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; or32 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (ov32) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL mid_stale_result: got %0d valid cycles want 0", seen); else pass_cnt++;
    xact32(32'd9, 32'd1, 32'd0, 32'd0, 4'hA, rq, rovf, rtag, lat);
    chk_cnt++; if (lat !== 4) $display("FAIL mid_new_latency: got %0d want 4", lat); else pass_cnt++;
    chk_cnt++; if (rq !== 32'd4 || rtag !== 4'hA) $display("FAIL mid_new_result: got q=%0d tag=%h want q=4 tag=a", rq, rtag); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
